fetch_pc_queue: RTL and testbench
=================================

Name: fetch_pc_queue

Overview:
- Parametrised next-generation fetch-address generator for the RV64IMFD stage 1.
- Holds the fetch PC and picks the next PC by fixed priority: trap vector, mispredict target, fence refetch, predicted-taken target, sequential PC.
- The branch predictor sits outside this block and is looked up with the current PC.
- Generated addresses, with their prediction bits, are buffered in a small fetch-address queue that feeds stage 2 over a valid/ready handshake. Any redirect flushes the queue.

Parameters:
XLEN, 64, address width
RESET_VEC, 64'h0, PC loaded on reset
FQ_DEPTH, 4, fetch-address queue entries (power of two, >=2)
INSTR_BYTES, 4, sequential increment

Ports:
clk  input  1  clock
rst  input  1  reset; one clock; reset is synchronous and active-high
trap_valid  input  1  trap/interrupt redirect request
trap_vec  input  XLEN  trap handler address
mispred  input  1  branch/jump mispredict from execute
mispred_pc  input  XLEN  correct target
fence_flush  input  1  FENCE.I retire; refetch after fence
fence_pc  input  XLEN  PC of the retiring FENCE.I
bp_hit  input  1  predictor hit for pc_o (combinational, same cycle)
bp_taken  input  1  predictor says taken
bp_target  input  XLEN  predicted target
pc_o  output  XLEN  current fetch PC, used for the predictor lookup
flush_o  output  1  registered; high for one cycle after any redirect
out_valid  output  1  queue head valid
out_ready  input  1  stage 2 accepts the head
out_addr  output  XLEN  head fetch address
out_pred_taken  output  1  head was predicted taken
out_pred_target  output  XLEN  head predicted target (0 if not taken)

Behaviour:
- Reset (rst high at a clk edge):
  - pc <= RESET_VEC.
  - Queue count/head/tail <= 0.
  - flush_o <= 0.
  - out_valid = 0; out_addr and out_pred_target read as 0 while empty.
- Redirect priority in any cycle: trap_valid > mispred > fence_flush.
  - Next PC is trap_vec, mispred_pc, or fence_pc+INSTR_BYTES respectively.
  - Bits [1:0] of the redirect target are forced to 0.
- Redirect cycle:
  - pc <= target.
  - Queue cleared (count, head, tail <= 0). Any simultaneous pop is discarded.
  - No push that cycle.
  - flush_o <= 1 next cycle.
- Predicted taken = bp_hit & bp_taken & (bp_target[1:0]==0). A misaligned predicted target is treated as not taken.
- Push when there is no redirect and (count<FQ_DEPTH or a pop occurs the same cycle):
  - Write {pc, pred_taken, pred_taken ? bp_target : 0} at tail.
  - pc <= pred_taken ? bp_target : pc+INSTR_BYTES.
- Otherwise pc holds (stall).
- Pop when out_valid & out_ready; head advances.
- Output timing: out_* driven combinationally from the head entry. Latency from pc_o presentation to out_valid is 1 cycle when the queue is empty.
- Full queue: count==FQ_DEPTH blocks the push unless a pop happens the same cycle. Simultaneous push and pop on a full queue keeps count unchanged.
- Empty queue: out_valid=0; out_ready is ignored.
- Arithmetic:
  - pc+INSTR_BYTES wraps modulo 2^XLEN (all-ones-3 -> 0).
  - head and tail wrap modulo FQ_DEPTH.
  - count is $clog2(FQ_DEPTH)+1 bits.
- Mid-operation reset: rst has priority over every redirect and over the handshake.
- pc_o always equals the pc register.

Decomposition:
- Package fetch_pkg: XLEN default, INSTR_BYTES, fq_entry_t struct {addr, pred_taken, pred_target}, redirect_src_e enum {RS_NONE, RS_TRAP, RS_MISPRED, RS_FENCE}.
- One sub-module, fetch_addr_fifo:
  - Parametrised on depth and entry type.
  - Has sync clear (flush), push/pop, full/empty, and same-cycle push+pop on full.
- The top level holds the PC register and the redirect/next-PC mux.

Test Plan:
- Reset, then out_ready=1, no predictions -> out_addr sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles, starting 1 cycle after reset deasserts; flush_o=0.
- bp_hit=1, bp_taken=1, bp_target=0x100 when pc_o=0x8 -> entry {0x8, taken=1, target=0x100}; next pc_o=0x100. Same stimulus with bp_target=0x102 -> treated as not taken, next pc_o=0xC.
- out_ready=0 for 6 cycles from reset -> 4 entries queued (0x0-0xC), pc_o holds at 0x10. Raising out_ready then gives 0x0 popped and 0x10 pushed in the same cycle, count stays 4.
- Queue holds 3 entries; assert trap_valid, mispred, fence_flush together with trap_vec=0x800, mispred_pc=0x200, fence_pc=0x300 -> next cycle pc_o=0x800, out_valid=0, flush_o=1 for exactly 1 cycle.
- fence_flush alone with fence_pc=0x40 -> pc_o=0x44. mispred_pc=0x203 -> pc_o=0x200.
- pc at 0xFFFF_FFFF_FFFF_FFFC -> next pc_o=0x0. Assert rst while queue is full and mispred=1 -> pc_o=RESET_VEC, out_valid=0, flush_o=0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-address generator and its queue.
package fetch_pkg;

  localparam int XLEN_DEFAULT        = 64;
  localparam int INSTR_BYTES_DEFAULT = 4;

  // One queued fetch request: address plus the prediction made for it.
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] addr;
    logic                    pred_taken;
    logic [XLEN_DEFAULT-1:0] pred_target;
  } fq_entry_t;

  typedef enum logic [1:0] {
    RS_NONE,
    RS_TRAP,
    RS_MISPRED,
    RS_FENCE
  } redirect_src_e;

  // Instruction addresses are always 4-byte aligned; drop the low two bits.
  function automatic logic [XLEN_DEFAULT-1:0] align_word(input logic [XLEN_DEFAULT-1:0] a);
    return {a[XLEN_DEFAULT-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_addr_fifo.sv
// Small circular FIFO for fetch requests. Synchronous clear drops all
// entries; a push is accepted on a full queue only when a pop frees a slot
// in the same cycle.
module fetch_addr_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   push,
  input  logic   pop,
  input  entry_t din,
  output entry_t dout,
  output logic   full,
  output logic   empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            do_push;
  logic            do_pop;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[head_reg];

  // Occupancy follows the accepted push/pop pair.
  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + CW'(1);
    end else if (do_pop && !do_push) begin
      count_next = count_reg - CW'(1);
    end
  end

  // Pointers and count; reset and clear both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (do_push) tail_reg <= tail_reg + PW'(1);
      if (do_pop)  head_reg <= head_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  // Storage: each slot captures din when the tail points at it.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (do_push && !clear && !rst && (tail_reg == PW'(gi))) begin
          mem[gi] <= din;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/fetch_pc_queue.sv
// Fetch PC register, redirect/next-PC selection and the fetch-address queue
// that feeds stage 2.
module fetch_pc_queue
  import fetch_pkg::*;
#(
  parameter int               XLEN        = XLEN_DEFAULT,
  parameter logic [XLEN-1:0]  RESET_VEC   = '0,
  parameter int               FQ_DEPTH    = 4,
  parameter int               INSTR_BYTES = INSTR_BYTES_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_vec,
  input  logic            mispred,
  input  logic [XLEN-1:0] mispred_pc,
  input  logic            fence_flush,
  input  logic [XLEN-1:0] fence_pc,
  input  logic            bp_hit,
  input  logic            bp_taken,
  input  logic [XLEN-1:0] bp_target,
  output logic [XLEN-1:0] pc_o,
  output logic            flush_o,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_addr,
  output logic            out_pred_taken,
  output logic [XLEN-1:0] out_pred_target
);

  // Entry struct width is fixed by the package; XLEN must match it.
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] pc_next;
  logic            flush_reg;
  redirect_src_e   redirect_src;
  logic [XLEN-1:0] redirect_raw;
  logic            redirect;
  logic            pred_taken;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  fq_entry_t       push_entry;
  fq_entry_t       head_entry;

  // Redirect source by fixed priority: trap, mispredict, fence refetch.
  always_comb begin
    redirect_src = RS_NONE;
    redirect_raw = '0;
    if (trap_valid) begin
      redirect_src = RS_TRAP;
      redirect_raw = trap_vec;
    end else if (mispred) begin
      redirect_src = RS_MISPRED;
      redirect_raw = mispred_pc;
    end else if (fence_flush) begin
      redirect_src = RS_FENCE;
      redirect_raw = fence_pc + XLEN'(INSTR_BYTES);
    end
  end

  assign redirect = (redirect_src != RS_NONE);

  // A misaligned predicted target is not trusted and falls back to sequential.
  assign pred_taken = bp_hit & bp_taken & (bp_target[1:0] == 2'b00);

  assign pop  = ~fifo_empty & out_ready;
  assign push = ~redirect & (~fifo_full | pop);

  assign push_entry.addr        = pc_reg;
  assign push_entry.pred_taken  = pred_taken;
  assign push_entry.pred_target = pred_taken ? bp_target : '0;

  // Next PC: redirect target, else advance only when this PC was queued.
  always_comb begin
    pc_next = pc_reg;
    if (redirect) begin
      pc_next = align_word(redirect_raw);
    end else if (push) begin
      pc_next = pred_taken ? bp_target : pc_reg + XLEN'(INSTR_BYTES);
    end
  end

  // PC register and the one-cycle flush pulse after any redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_VEC;
      flush_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      flush_reg <= redirect;
    end
  end

  fetch_addr_fifo #(
    .DEPTH   (FQ_DEPTH),
    .entry_t (fq_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pc_o            = pc_reg;
  assign flush_o         = flush_reg;
  assign out_valid       = ~fifo_empty;
  assign out_addr        = fifo_empty ? '0 : head_entry.addr;
  assign out_pred_taken  = fifo_empty ? 1'b0 : head_entry.pred_taken;
  assign out_pred_target = fifo_empty ? '0 : head_entry.pred_target;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Scoreboard bench for fetch_pc_queue: the stimulus process runs a
// queue-based reference model and pushes expected entries; a monitor on the
// falling edge compares the head, pc_o and flush_o.
module tb_fetch_pc_queue;

  localparam logic [63:0] RESET_VEC = 64'h0;
  localparam int          DEPTH     = 4;

  logic        clk;
  logic        rst;
  logic        trap_valid;
  logic [63:0] trap_vec;
  logic        mispred;
  logic [63:0] mispred_pc;
  logic        fence_flush;
  logic [63:0] fence_pc;
  logic        bp_hit;
  logic        bp_taken;
  logic [63:0] bp_target;
  logic [63:0] pc_o;
  logic        flush_o;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_addr;
  logic        out_pred_taken;
  logic [63:0] out_pred_target;

  fetch_pc_queue #(
    .XLEN        (64),
    .RESET_VEC   (RESET_VEC),
    .FQ_DEPTH    (DEPTH),
    .INSTR_BYTES (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .trap_valid      (trap_valid),
    .trap_vec        (trap_vec),
    .mispred         (mispred),
    .mispred_pc      (mispred_pc),
    .fence_flush     (fence_flush),
    .fence_pc        (fence_pc),
    .bp_hit          (bp_hit),
    .bp_taken        (bp_taken),
    .bp_target       (bp_target),
    .pc_o            (pc_o),
    .flush_o         (flush_o),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_addr        (out_addr),
    .out_pred_taken  (out_pred_taken),
    .out_pred_target (out_pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] addr;
    logic        taken;
    logic [63:0] tgt;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_pc;
  bit          m_flush;
  bit          mon_en;
  int          checks;
  int          failures;
  int          pops;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: everything the DUT shows mid-cycle must match the model.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("pc_o", pc_o, m_pc);
      chk("flush_o", {63'd0, flush_o}, {63'd0, m_flush});
      chk("out_valid", {63'd0, out_valid}, {63'd0, (sb.size() != 0)});
      if (sb.size() != 0) begin
        chk("out_addr", out_addr, sb[0].addr);
        chk("out_pred_taken", {63'd0, out_pred_taken}, {63'd0, sb[0].taken});
        chk("out_pred_target", out_pred_target, sb[0].tgt);
        if (out_ready) begin
          pops++;
          $display("pop #%0d addr=%h taken=%0d target=%h", pops, out_addr, out_pred_taken, out_pred_target);
          void'(sb.pop_front());
        end
      end else begin
        chk("empty_addr", out_addr, 64'd0);
        chk("empty_target", out_pred_target, 64'd0);
      end
    end
  end

  // One cycle of stimulus plus the model's view of what that cycle does.
  task automatic step(input bit r, input bit tv, input logic [63:0] tvec,
                      input bit mp, input logic [63:0] mpc,
                      input bit ff, input logic [63:0] fpc,
                      input bit hit, input bit tk, input logic [63:0] tgt,
                      input bit rdy);
    bit          p_clear;
    bit          p_push;
    bit          p_flush;
    bit          taken;
    logic [63:0] p_pc;
    logic [63:0] dest;
    exp_t        ent;
    bit          pop_now;
    rst = r; trap_valid = tv; trap_vec = tvec; mispred = mp; mispred_pc = mpc;
    fence_flush = ff; fence_pc = fpc; bp_hit = hit; bp_taken = tk;
    bp_target = tgt; out_ready = rdy;
    pop_now = (sb.size() > 0) && rdy;
    p_clear = 0; p_push = 0; p_flush = 0; p_pc = m_pc; ent = '0;
    if (r) begin
      p_clear = 1;
      p_pc    = RESET_VEC;
    end else if (tv || mp || ff) begin
      dest    = tv ? tvec : (mp ? mpc : fpc + 64'd4);
      p_pc    = dest & ~64'd3;
      p_clear = 1;
      p_flush = 1;
    end else begin
      taken = hit && tk && (tgt % 4 == 0);
      if (sb.size() < DEPTH || pop_now) begin
        p_push = 1;
        ent    = '{addr: m_pc, taken: taken, tgt: (taken ? tgt : 64'd0)};
        p_pc   = taken ? tgt : m_pc + 64'd4;
      end
    end
    @(posedge clk);
    #1;
    if (p_clear) sb.delete();
    if (p_push) sb.push_back(ent);
    m_pc    = p_pc;
    m_flush = p_flush;
    mon_en  = 1;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  task automatic reset_cycle();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [63:0] rv;
    logic [63:0] rt;
    checks = 0; failures = 0; pops = 0; mon_en = 0;
    m_pc = RESET_VEC; m_flush = 0;
    rst = 1; trap_valid = 0; trap_vec = 0; mispred = 0; mispred_pc = 0;
    fence_flush = 0; fence_pc = 0; bp_hit = 0; bp_taken = 0; bp_target = 0;
    out_ready = 0;

    // Sequential stream after reset.
    reset_cycle(); reset_cycle();
    for (int i = 0; i < 6; i++) idle(1);

    // Predicted-taken at 0x8, then a misaligned target at 0x8.
    reset_cycle(); idle(1); idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h100, 1);
    idle(1); idle(1);
    reset_cycle(); idle(1); idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 64'h102, 1);
    idle(1); idle(1);

    // Fill with ready low, then push and pop together on a full queue.
    reset_cycle();
    for (int i = 0; i < 6; i++) idle(0);
    for (int i = 0; i < 3; i++) idle(1);

    // All three redirects at once with three entries queued.
    reset_cycle();
    for (int i = 0; i < 3; i++) idle(0);
    step(0, 1, 64'h800, 1, 64'h200, 1, 64'h300, 0, 0, 0, 1);
    idle(1); idle(1);

    // Fence alone, then a misaligned mispredict target.
    step(0, 0, 0, 0, 0, 1, 64'h40, 0, 0, 0, 1);
    idle(1);
    step(0, 0, 0, 1, 64'h203, 0, 0, 0, 0, 0, 1);
    idle(1);

    // Wrap of the sequential increment.
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(1); idle(1);

    // Reset wins over a mispredict while the queue is full.
    for (int i = 0; i < 6; i++) idle(0);
    step(1, 0, 0, 1, 64'h500, 0, 0, 0, 0, 0, 1);
    idle(0); idle(1);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      rv = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                       : {$urandom(), $urandom()};
      rt = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 29) == 0), rv,
           ($urandom_range(0, 24) == 0), {$urandom(), $urandom()},
           ($urandom_range(0, 24) == 0), {$urandom(), $urandom()},
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), rt,
           ($urandom_range(0, 9) < 6));
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
